// File: rtl/display_sched_pkg.sv
// disp_pkg: shared types, widths and round-robin index helper for the display scheduler
package disp_pkg;
    typedef enum logic [1:0] {IDLE, SWITCH, OWN} state_t;
    localparam int DIGITS = 4;
    localparam int BCD_W = 4;
    typedef logic [DIGITS*BCD_W-1:0] bcd_word_t;
    function automatic logic [2:0] wrap_add(logic [2:0] base, int off, int n);
        int s = int'(base) + off;
        return 3'(s >= n ? s - n : s);
    endfunction
endpackage

// File: rtl/display_sched_if.sv
// display_sched_if: requester bundle in, grant status and display driver digits out
interface display_sched_if #(parameter int N_REQ = 3);
    import disp_pkg::*;
    logic [N_REQ-1:0] req;
    logic [N_REQ*DIGITS*BCD_W-1:0] req_data;
    logic [N_REQ-1:0] gnt;
    logic [2:0] owner;
    logic busy;
    logic [BCD_W-1:0] d0, d1, d2, d3;
    logic blank;
    modport master(output req, req_data, input gnt, owner, busy, d0, d1, d2, d3, blank);
    modport slave(input req, req_data, output gnt, owner, busy, d0, d1, d2, d3, blank);
endinterface

// File: rtl/display_sched_rr_pick.sv
// rr_pick: combinational round-robin search starting at rr_ptr
module rr_pick import disp_pkg::*; #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr_ptr,
    output logic [2:0]       winner,
    output logic             any
);
    // scan offsets from farthest to nearest so the nearest asserted request is kept
    always_comb begin
        winner = '0;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(rr_ptr, i, N_REQ)]) begin
                winner = wrap_add(rr_ptr, i, N_REQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/display_sched.sv
// display_sched: round-robin display sharing with minimum hold and blank handover gap; optional DISP_BLINK_EN blinks owner 0
module display_sched import disp_pkg::*; #(
    parameter int N_REQ     = 3,
    parameter int HOLD_CYC  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input logic clk,
    input logic rst,
    display_sched_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    state_t state, state_n;
    logic [2:0] rr_ptr, rr_ptr_n, owner, owner_n, winner;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic any, own_req, others, stay, busy, busy_n, blank, blank_n, own_blank;
    bcd_word_t d, d_n;
    rr_pick #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .rr_ptr(rr_ptr), .winner(winner), .any(any));
    assign own_req = |(bus.req & gnt);
    assign others = |(bus.req & ~gnt);
    assign stay = own_req && !(hold_cnt == HW'(HOLD_CYC) && others);
`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] blink_cnt, blink_n;
    logic blink_wrap;
    assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    assign blink_n = (state == OWN && stay && !blink_wrap) ? blink_cnt + 1'b1 : '0;
    assign own_blank = (blink_wrap && owner == 3'd0) ? ~blank : blank;
    // blink phase counter, restarted on every handover
    always_ff @(posedge clk or posedge rst)
        if (rst) blink_cnt <= '0;
        else blink_cnt <= blink_n;
`else
    assign own_blank = 1'b0;
`endif
    // next state and next output values; anything not owning shows a dark, ungranted display
    always_comb begin
        state_n = state;
        rr_ptr_n = rr_ptr;
        owner_n = owner;
        hold_n = '0;
        gnt_n = '0;
        busy_n = 1'b0;
        d_n = '0;
        blank_n = 1'b1;
        case (state)
            IDLE: state_n = |bus.req ? SWITCH : IDLE;
            SWITCH: begin
                state_n = any ? OWN : IDLE;
                if (any) begin
                    rr_ptr_n = wrap_add(winner, 1, N_REQ);
                    owner_n = winner;
                    gnt_n = N_REQ'(1) << winner;
                    busy_n = 1'b1;
                    d_n = bus.req_data[{winner, 4'b0} +: 16];
                    blank_n = 1'b0;
                end
            end
            default: begin
                state_n = stay ? OWN : (others ? SWITCH : IDLE);
                if (stay) begin
                    hold_n = hold_cnt == HW'(HOLD_CYC) ? hold_cnt : hold_cnt + 1'b1;
                    gnt_n = gnt;
                    busy_n = 1'b1;
                    d_n = bus.req_data[{owner, 4'b0} +: 16];
                    blank_n = own_blank;
                end
            end
        endcase
    end
    // FSM state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // arbitration bookkeeping and registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            owner <= '0;
            hold_cnt <= '0;
            gnt <= '0;
            busy <= 1'b0;
            d <= '0;
            blank <= 1'b1;
        end else begin
            rr_ptr <= rr_ptr_n;
            owner <= owner_n;
            hold_cnt <= hold_n;
            gnt <= gnt_n;
            busy <= busy_n;
            d <= d_n;
            blank <= blank_n;
        end
    end
    assign bus.gnt = gnt;
    assign bus.owner = owner;
    assign bus.busy = busy;
    assign {bus.d3, bus.d2, bus.d1, bus.d0} = d;
    assign bus.blank = blank;
endmodule

// File: tb/tb_display_sched.sv
// tb_display_sched: vector table, corner sequences and randomized run against a behavioural model
module tb_display_sched;
    import disp_pkg::*;
    localparam int N = 3, HOLD = 4, BDIV = 2;
`ifdef DISP_BLINK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, mon = 1'b0;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    display_sched_if #(.N_REQ(N)) bus ();
    display_sched #(.N_REQ(N), .HOLD_CYC(HOLD), .BLINK_DIV(BDIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'b0, bus.gnt, bus.busy, bus.d3, bus.d2, bus.d1, bus.d0, bus.blank};
    endfunction

    function automatic logic [15:0] word(int i);
        return 16'(bus.req_data >> (16 * i));
    endfunction

    // model: -1 idle, -2 handover gap, otherwise index of owner; age counts cycles owned
    int m_cur, m_age, m_ptr, m_owner;
    logic [15:0] m_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cur = -1; m_age = 0; m_ptr = 0; m_owner = 0; m_d = '0;
        end else if (m_cur == -1) begin
            if (bus.req != 0) m_cur = -2;
        end else if (m_cur == -2) begin
            int w;
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && bus.req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            if (w < 0) m_cur = -1;
            else begin
                m_cur = w; m_owner = w; m_age = 0; m_ptr = (w + 1) % N; m_d = word(w);
            end
        end else begin
            bit oth;
            oth = (bus.req & ~(3'(1) << m_cur)) != 0;
            if (!bus.req[m_cur] || (m_age >= HOLD && oth)) m_cur = oth ? -2 : -1;
            else begin
                m_age++; m_d = word(m_cur);
            end
        end
    end

    always @(negedge clk) if (mon) begin
        logic [2:0] eg;
        logic eb, ebl;
        eg = m_cur >= 0 ? 3'(1 << m_cur) : 3'b0;
        eb = m_cur >= 0;
        ebl = m_cur < 0 ? 1'b1 : (BL && m_cur == 0 && ((m_age / BDIV) % 2 == 1));
        chk("model", {8'b0, bus.gnt, bus.busy, bus.d3, bus.d2, bus.d1, bus.d0, bus.blank, bus.busy ? bus.owner : 3'b0},
            {8'b0, eg, eb, (eb ? m_d : 16'h0), ebl, (eb ? 3'(m_owner) : 3'b0)});
    end

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1; bus.req = '0;
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] req; logic [15:0] d0; int cyc;
        logic [2:0] gnt; logic busy; logic [15:0] d; logic blank;
    } vec_t;
    vec_t tbl [9];

    initial begin
        tbl[0] = '{3'b000, 16'h1234, 1, 3'b000, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{3'b001, 16'h1234, 2, 3'b001, 1'b1, 16'h1234, 1'b0};
        tbl[2] = '{3'b001, 16'h1234, 1, 3'b001, 1'b1, 16'h1234, 1'b0};
        tbl[3] = '{3'b001, 16'h4321, 1, 3'b001, 1'b1, 16'h4321, BL};
        tbl[4] = '{3'b000, 16'h1234, 1, 3'b000, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{3'b100, 16'h1234, 2, 3'b100, 1'b1, 16'h9abc, 1'b0};
        tbl[6] = '{3'b110, 16'h1234, 1, 3'b100, 1'b1, 16'h9abc, 1'b0};
        tbl[7] = '{3'b010, 16'h1234, 1, 3'b000, 1'b0, 16'h0000, 1'b1};
        tbl[8] = '{3'b010, 16'h1234, 1, 3'b010, 1'b1, 16'h5678, 1'b0};
        bus.req = '0;
        bus.req_data = {16'h9abc, 16'h5678, 16'h1234};
        repeat (2) @(negedge clk);
        chk("reset", {outs()[31:0]} ^ {29'b0, bus.owner}, {31'b0, 1'b1});
        #2 rst = 1'b0; mon = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            bus.req = tbl[i].req;
            bus.req_data[15:0] = tbl[i].d0;
            repeat (tbl[i].cyc) @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), {11'b0, tbl[i].gnt, tbl[i].busy, tbl[i].d, tbl[i].blank});
        end
        bus.req_data[15:0] = 16'h1234;
        #2 rst = 1'b1;
        #1 chk("rst_async", outs(), 32'h1);
        bus.req = '0;
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", outs(), 32'h1);
        bus.req = 3'b111;
        for (int k = 1; k <= 24; k++) begin
            logic [2:0] eg;
            @(negedge clk);
            eg = (k < 2 || (k - 2) % 6 == 5) ? 3'b000 : 3'(1 << (((k - 2) / 6) % 3));
            chk($sformatf("rr_k%0d", k), 32'(bus.gnt), 32'(eg));
        end
        do_reset();
        bus.req = 3'b010;
        repeat (2) @(negedge clk);
        chk("er_own1", 32'(bus.gnt), 32'b010);
        bus.req = 3'b110;
        @(negedge clk);
        chk("er_hold1", 32'(bus.gnt), 32'b010);
        bus.req = 3'b100;
        @(negedge clk);
        chk("er_switch", {28'b0, bus.gnt, bus.blank}, {28'b0, 3'b000, 1'b1});
        @(negedge clk);
        chk("er_gnt2", outs(), {11'b0, 3'b100, 1'b1, 16'h9abc, 1'b0});
        do_reset();
        bus.req = 3'b010;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            chk("lone", 32'(bus.gnt), 32'b010);
            @(negedge clk);
        end
        bus.req = '0;
        @(negedge clk);
        chk("lone_drop", {29'b0, bus.gnt[0] | bus.gnt[1] | bus.gnt[2], bus.busy, bus.blank}, 32'b001);
        do_reset();
        bus.req = 3'b001;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blink%0d", i), 32'(bus.blank), BL ? 32'((i / 2) % 2) : 32'h0);
            @(negedge clk);
        end
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) bus.req[b] = ~bus.req[b];
            bus.req_data = 48'({$urandom(), $urandom()});
        end
        @(negedge clk);
        mon = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
